// File: rtl/fir_pkg.sv
// Shared types and helpers for the folded FIR sequencer.
// No logic of its own; zero latency.
// No flow control; consumed by the sequencer and its MAC stage.
package fir_pkg;

  // Sequencer phases: wait for a sample, run TAPS MACs, present the result.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } fir_seq_state_t;

  localparam int FIR_DEF_N    = 32;
  localparam int FIR_DEF_TAPS = 8;

  // Width of a tap index; never below one bit so a degenerate tap count still elaborates.
  function automatic int fir_idx_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_stage.sv
// Single multiply-accumulate term: y_out = x*b + y_in, all modulo 2^N.
// Purely combinational, zero latency.
// No flow control; the sequencer decides when the result is captured.
module fir_mac_stage
  import fir_pkg::*;
#(
  parameter int N = FIR_DEF_N
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] b,
  input  logic [N-1:0] y_in,
  output logic [N-1:0] y_out
);

  // Self-determined N-bit context truncates both the product and the sum.
  assign y_out = x * b + y_in;

endmodule

// File: rtl/fir_fold_sequencer.sv
// Folded FIR: one shared MAC stepped over TAPS taps against a sample history ring.
// Latency: m_valid rises TAPS edges after the accepting edge; one sample per TAPS+2 cycles max.
// Backpressure: result held in HOLD until m_ready; s_ready low outside IDLE.
module fir_fold_sequencer
  import fir_pkg::*;
#(
  parameter  int N    = FIR_DEF_N,
  parameter  int TAPS = FIR_DEF_TAPS,
  localparam int IW   = fir_idx_w(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_we,
  input  logic [IW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic          coef_err,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [N-1:0]  m_data
);

  // TAPS expressed one bit wider than an index so it is representable for power-of-two counts.
  localparam logic [IW:0]   TAPS_X = (IW + 1)'(TAPS);
  localparam logic [IW-1:0] LAST   = IW'(TAPS - 1);

  fir_seq_state_t state_q, state_d;

  logic [N-1:0]  ring [TAPS];
  logic [N-1:0]  coef [TAPS];
  logic [IW-1:0] wr_ptr_q;
  logic [IW-1:0] newest_q;
  logic [IW-1:0] k_q;
  logic [N-1:0]  acc_q;
  logic [N-1:0]  m_data_q;
  logic          m_valid_q;
  logic          coef_err_q;

  logic          accept;
  logic          mac_en;
  logic          last_tap;
  logic          release_out;
  logic          addr_ok;
  logic          coef_wr_ok;
  logic [IW-1:0] wr_ptr_nxt;
  logic [IW-1:0] rd_idx;
  logic [N-1:0]  mac_y;

  // Phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase and per-cycle control strobes.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    mac_en      = 1'b0;
    last_tap    = 1'b0;
    release_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          accept  = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        mac_en = 1'b1;
        if (k_q == LAST) begin
          last_tap = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          release_out = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ring read index (newest - k) mod TAPS and write pointer advance, both by explicit compare.
  always_comb begin
    addr_ok    = ({1'b0, coef_addr} < TAPS_X);
    coef_wr_ok = coef_we && (state_q == S_IDLE) && addr_ok;
    wr_ptr_nxt = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + IW'(1);
    if (k_q <= newest_q) begin
      rd_idx = newest_q - k_q;
    end else begin
      rd_idx = IW'({1'b0, newest_q} + TAPS_X - {1'b0, k_q});
    end
  end

  fir_mac_stage #(.N(N)) u_mac (
    .x     (ring[rd_idx]),
    .b     (coef[k_q]),
    .y_in  (acc_q),
    .y_out (mac_y)
  );

  // Sample history and coefficient storage; a write in the accept cycle is seen by that sample's MACs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        ring[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (coef_wr_ok) begin
        coef[coef_addr] <= coef_data;
      end
      if (accept) begin
        ring[wr_ptr_q] <= s_data;
      end
    end
  end

  // Pointers, tap counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      newest_q   <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= coef_we && !coef_wr_ok;
      if (accept) begin
        newest_q <= wr_ptr_q;
        wr_ptr_q <= wr_ptr_nxt;
        acc_q    <= '0;
        k_q      <= '0;
      end
      if (mac_en) begin
        acc_q <= mac_y;
        k_q   <= last_tap ? '0 : k_q + IW'(1);
        if (last_tap) begin
          m_data_q  <= mac_y;
          m_valid_q <= 1'b1;
        end
      end
      if (release_out) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign s_ready  = rst_n && (state_q == S_IDLE);
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign coef_err = coef_err_q;

endmodule

// File: tb/tb_fir_fold_sequencer.sv
// Directed plus randomized bench for the folded FIR sequencer.
// Two instances: TAPS=4 (main scenarios) and TAPS=5 (non-power-of-two wrap, bad address).
// Reference: plain sum of coef[k]*x[n-k] over a shift-register history.
module tb_fir_fold_sequencer;

  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cwe   [2];
  logic [1:0]    caddr0;
  logic [2:0]    caddr1;
  logic [N-1:0]  cdata [2];
  logic          cerr  [2];
  logic          sv    [2];
  logic          srdy  [2];
  logic [N-1:0]  sd    [2];
  logic          mv    [2];
  logic          mr    [2];
  logic [N-1:0]  md    [2];

  logic [N-1:0]  coef_m [2][8];
  logic [N-1:0]  hist_m [2][8];
  int            tests;
  int            fails;
  logic [N-1:0]  got;

  fir_fold_sequencer #(.N(N), .TAPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .coef_we(cwe[0]), .coef_addr(caddr0), .coef_data(cdata[0]), .coef_err(cerr[0]),
    .s_valid(sv[0]), .s_ready(srdy[0]), .s_data(sd[0]),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0])
  );

  fir_fold_sequencer #(.N(N), .TAPS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .coef_we(cwe[1]), .coef_addr(caddr1), .coef_data(cdata[1]), .coef_err(cerr[1]),
    .s_valid(sv[1]), .s_ready(srdy[1]), .s_data(sd[1]),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1])
  );

  function automatic int taps_of(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic logic [N-1:0] model_out(input int d);
    longint unsigned s;
    s = 0;
    for (int k = 0; k < taps_of(d); k++) begin
      s += longint'(coef_m[d][k]) * longint'(hist_m[d][k]);
    end
    return N'(s);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        coef_m[d][k] = '0;
        hist_m[d][k] = '0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int d, input int a);
    if (d == 0) caddr0 = 2'(a);
    else        caddr1 = 3'(a);
  endtask

  task automatic wr_coef(input int d, input int addr, input logic [N-1:0] data, input bit expect_err);
    @(negedge clk);
    cwe[d] = 1'b1;
    set_addr(d, addr);
    cdata[d] = data;
    @(posedge clk);
    if (!expect_err) coef_m[d][addr] = data;
    @(negedge clk);
    cwe[d] = 1'b0;
    chk("coef_err_write", 32'(cerr[d]), 32'(expect_err));
  endtask

  // mode 0: plain; 1: coefficient write attempted during ACCUM; 2: write alongside accept.
  task automatic send(input int d, input logic [N-1:0] x, input int hold, input int mode,
                      output logic [N-1:0] y);
    int           edges;
    int           wa;
    logic [N-1:0] wd;
    logic [N-1:0] exp_y;
    wa = 0;
    wd = '0;
    @(negedge clk);
    chk("s_ready_idle", 32'(srdy[d]), 32'd1);
    sv[d] = 1'b1;
    sd[d] = x;
    mr[d] = 1'b0;
    if (mode == 2) begin
      wa = int'($urandom_range(taps_of(d) - 1));
      wd = N'($urandom);
      cwe[d] = 1'b1;
      set_addr(d, wa);
      cdata[d] = wd;
    end
    @(posedge clk);
    edges = 1;
    if (mode == 2) coef_m[d][wa] = wd;
    for (int k = 7; k > 0; k--) hist_m[d][k] = hist_m[d][k-1];
    hist_m[d][0] = x;
    exp_y = model_out(d);
    @(negedge clk);
    sv[d] = 1'b0;
    if (mode == 2) begin
      cwe[d] = 1'b0;
      chk("coef_err_accept", 32'(cerr[d]), 32'd0);
    end
    if (mode == 1) begin
      cwe[d] = 1'b1;
      set_addr(d, 0);
      cdata[d] = ~coef_m[d][0];
    end
    while (mv[d] !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (mode == 1 && edges == 2) begin
        chk("coef_err_busy", 32'(cerr[d]), 32'd1);
        cwe[d] = 1'b0;
      end
      if (mode == 1 && edges == 3) chk("coef_err_pulse_end", 32'(cerr[d]), 32'd0);
    end
    chk("latency_edges", 32'(edges), 32'(taps_of(d) + 1));
    chk("m_data", 32'(md[d]), 32'(exp_y));
    chk("busy_s_ready", 32'(srdy[d]), 32'd0);
    y = md[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(mv[d]), 32'd1);
      chk("hold_data", 32'(md[d]), 32'(exp_y));
      chk("hold_s_ready", 32'(srdy[d]), 32'd0);
    end
    mr[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mr[d] = 1'b0;
    chk("release_valid", 32'(mv[d]), 32'd0);
    chk("release_s_ready", 32'(srdy[d]), 32'd1);
  endtask

  logic [N-1:0] imp_in  [4] = '{16'd1, 16'd0, 16'd0, 16'd0};
  logic [N-1:0] imp_out [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
  logic [N-1:0] step_out[6] = '{16'd1, 16'd3, 16'd6, 16'd10, 16'd10, 16'd10};

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    caddr0 = '0;
    caddr1 = '0;
    for (int d = 0; d < 2; d++) begin
      cwe[d] = 1'b0; cdata[d] = '0; sv[d] = 1'b0; sd[d] = '0; mr[d] = 1'b0;
    end
    model_clear();

    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_s_ready", 32'(srdy[d]), 32'd0);
      chk("rst_m_valid", 32'(mv[d]), 32'd0);
      chk("rst_m_data", 32'(md[d]), 32'd0);
      chk("rst_coef_err", 32'(cerr[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(srdy[0]), 32'd1);

    // Reset during ACCUM aborts the computation
    for (int k = 0; k < 4; k++) wr_coef(0, k, N'(k + 1), 1'b0);
    @(negedge clk);
    sv[0] = 1'b1;
    sd[0] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    sv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_s_ready", 32'(srdy[0]), 32'd0);
      chk("midrst_m_valid", 32'(mv[0]), 32'd0);
      chk("midrst_m_data", 32'(md[0]), 32'd0);
    end
    rst_n = 1'b1;
    model_clear();
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      chk("after_rst_no_output", 32'(mv[0]), 32'd0);
      chk("after_rst_s_ready", 32'(srdy[0]), 32'd1);
    end

    // Impulse response
    for (int k = 0; k < 4; k++) wr_coef(0, k, N'(k + 1), 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(0, imp_in[i], 0, 0, got);
      chk("impulse_const", 32'(got), 32'(imp_out[i]));
    end

    // Step response across the ring wrap
    for (int i = 0; i < 6; i++) begin
      send(0, 16'd1, 0, 0, got);
      chk("step_const", 32'(got), 32'(step_out[i]));
    end

    // Backpressure: sink stalls five cycles
    send(0, 16'h0005, 5, 0, got);

    // Coefficient write while busy is dropped; the next sample proves coef[0] unchanged
    send(0, 16'h0007, 1, 1, got);
    send(0, 16'h0009, 0, 0, got);

    // Truncation: 0xFFFF * 0xFFFF mod 2^16
    wr_coef(0, 0, 16'hFFFF, 1'b0);
    for (int k = 1; k < 4; k++) wr_coef(0, k, 16'h0000, 1'b0);
    send(0, 16'hFFFF, 0, 0, got);
    chk("overflow_const", 32'(got), 32'h0001);

    // Randomized traffic on the 4-tap instance
    for (int k = 0; k < 4; k++) wr_coef(0, k, N'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) begin
      send(0, N'($urandom), int'($urandom_range(3)), int'($urandom_range(2)), got);
    end

    // 5-tap instance: out-of-range addresses rejected, non-power-of-two wrap
    for (int k = 0; k < 5; k++) wr_coef(1, k, N'($urandom), 1'b0);
    for (int a = 5; a < 8; a++) wr_coef(1, a, 16'hDEAD, 1'b1);
    for (int i = 0; i < 9; i++) begin
      send(1, N'($urandom), int'($urandom_range(2)), int'($urandom_range(2)), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
